dmem_responder: RTL and testbench

- Memory-side responder for data-memory load/store requests issued by the RV32I core (byte address, store data, funct3 size/sign code).
- Holds a word-organised RAM and accepts one request at a time over a valid/ready handshake.
- Returns a single-cycle response pulse after a programmable wait-state count.
- Performs RV32I byte/halfword/word lane selection, sign/zero extension and error detection (misaligned, illegal funct3, out of range).

---
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering RV32I load/store requests over a valid/ready handshake.
// The response is a one-cycle strobe after LATENCY wait states. It carries lane-extended load data or an error flag.
module dmem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high.
    // rsp_valid is a one-cycle strobe that cannot be stalled. rsp_rdata/rsp_err hold between strobes.

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [WIDTH-1:0]  r_addr;
    logic [WIDTH-1:0]  r_wdata;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_access;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic              w_oor;
    logic              w_fmt_err;
    logic              w_err;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [3:0]        w_be;
    logic [31:0]       w_wlane;
    logic              w_mem_we;

    assign w_accept = req_valid && req_ready;
    assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; LATENCY=0 still passes through WAIT with cnt=0 so the access lands at edge k+1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = 4'(LATENCY);
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = (r_state == ST_IDLE) && !reset;
        rsp_valid   = (r_state == ST_RESP);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    assign w_idx  = r_addr[IDX_W+1:2];
    assign w_lane = r_addr[1:0];
    assign w_oor  = |r_addr[WIDTH-1:IDX_W+2];

    always_comb begin
        w_fmt_err = 1'b0;
        if (r_we) begin
            case (r_funct3)
                3'b000:  w_fmt_err = 1'b0;
                3'b001:  w_fmt_err = r_addr[0];
                3'b010:  w_fmt_err = |r_addr[1:0];
                default: w_fmt_err = 1'b1;
            endcase
        end else begin
            case (r_funct3)
                3'b000, 3'b100: w_fmt_err = 1'b0;
                3'b001, 3'b101: w_fmt_err = r_addr[0];
                3'b010:         w_fmt_err = |r_addr[1:0];
                default:        w_fmt_err = 1'b1;
            endcase
        end
    end

    assign w_err  = w_fmt_err || w_oor;
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = 32'd0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the destination
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = 32'd0;
        case (r_funct3)
            3'b000: begin
                w_be    = 4'b0001 << w_lane;
                w_wlane = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            3'b010: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata[31:0];
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = 32'd0;
            end
        endcase
    end

    assign w_mem_we = w_access && r_we && !w_err;

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (w_access) begin
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || r_we) ? '0 : WIDTH'(w_load_data);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder.
// It uses a LATENCY=2 instance for most sequences and a LATENCY=0 instance for the zero-wait path.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  dbg_state;

    logic        l0_valid, l0_ready, l0_we, l0_rsp_valid, l0_rsp_err;
    logic [2:0]  l0_funct3;
    logic [31:0] l0_addr, l0_wdata, l0_rsp_rdata;
    logic [1:0]  l0_dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(64), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .o_dbg_state(dbg_state)
    );

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(64), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset), .req_valid(l0_valid), .req_ready(l0_ready),
        .req_we(l0_we), .req_funct3(l0_funct3), .req_addr(l0_addr), .req_wdata(l0_wdata),
        .rsp_valid(l0_rsp_valid), .rsp_rdata(l0_rsp_rdata), .rsp_err(l0_rsp_err), .o_dbg_state(l0_dbg_state)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance, called at a negedge, returns at a negedge in IDLE
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int  j;
        logic ready_seen;
        rd = '0;
        er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        j = 0;
        while (!req_ready && j < 20) begin
            @(negedge clk);
            j++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        j = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            j++;
            if (!rsp_valid && req_ready) ready_seen = 1'b1;
        end while (!rsp_valid && j < 20);
        check("rsp_latency", 32'(j), 32'(LAT + 2));
        check("ready_low_while_busy", 32'(ready_seen), 32'd0);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
        check("rdata_hold", rsp_rdata, rd);
    endtask

    // One transaction on the LATENCY=0 instance with cycle-exact checks
    task automatic l0_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        @(negedge clk);
        check("l0_ready_idle", 32'(l0_ready), 32'd1);
        l0_valid = 1'b1; l0_we = we; l0_funct3 = f3; l0_addr = a; l0_wdata = wd;
        @(posedge clk);
        #1;
        l0_valid = 1'b0;
        @(negedge clk);
        check("l0_no_rsp_edge_k", 32'(l0_rsp_valid), 32'd0);
        @(negedge clk);
        check("l0_rsp_edge_k1", 32'(l0_rsp_valid), 32'd1);
        check("l0_rdata", l0_rsp_rdata, exp_rd);
        check("l0_err", 32'(l0_rsp_err), 32'd0);
        @(negedge clk);
        check("l0_rsp_end", 32'(l0_rsp_valid), 32'd0);
        check("l0_ready_back", 32'(l0_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          last, naccept, nrsp, pulses;
        logic        toggle_pending, next_is_load;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        l0_valid = 1'b0; l0_we = 1'b0; l0_funct3 = 3'd0; l0_addr = '0; l0_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Basic store then load with latency checks inside do_req
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        check("sw10_rdata", rd, 32'd0);
        check("sw10_err", 32'(er), 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        check("lw10_rdata", rd, 32'hDEADBEEF);
        check("lw10_err", 32'(er), 32'd0);

        // Lane, extension and error vectors
        vecs.push_back('{1'b1, 3'b010, 32'h20,       32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h21,       32'h000000A5, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h22,       32'h00008001, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h20,       32'h0,        32'h8001A500, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h21,       32'h0,        32'hFFFFFFA5, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h21,       32'h0,        32'h000000A5, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h22,       32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h22,       32'h0,        32'h00008001, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h20,       32'h0,        32'hFFFFA500, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h12,       32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 32'h13,       32'h0000FFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h10,       32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b110, 32'h10,       32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h100,      32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h80000010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b100, 32'h20,       32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b010, 32'h102,      32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b010, 32'h20,       32'h0,        32'h8001A500, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h27,       32'h12345680, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h27,       32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h27,       32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'hFC,       32'h0BADF00D, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'hFC,       32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'hFE,       32'h0,        32'h00000BAD, 1'b0});

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Back-to-back with req_valid held high: SW then LW alternating at 0x40
        last = -1; naccept = 0; nrsp = 0;
        toggle_pending = 1'b0; next_is_load = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) begin
                check($sformatf("b2b_rsp%0d", nrsp), rsp_rdata, (nrsp % 2 == 1) ? 32'hCAFEF00D : 32'h0);
                nrsp++;
            end
            if (i < 20 && req_ready) begin
                if (last >= 0) check("b2b_gap", 32'(i - last), 32'(LAT + 3));
                last = i;
                naccept++;
                toggle_pending = 1'b1;
            end
            if (i >= 20) req_valid = 1'b0;
            @(posedge clk);
            #1;
            if (toggle_pending) begin
                req_we = !next_is_load;
                next_is_load = !next_is_load;
                toggle_pending = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_accepts", 32'(naccept), 32'd4);
        check("b2b_responses", 32'(nrsp), 32'd4);

        // Reset during WAIT aborts an uncommitted store and clears the response registers
        do_req(1'b1, 3'b010, 32'h30, 32'h00000000, rd, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        check("pre_reset_lw", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_abort_state", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_err", 32'(rsp_err), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er);
        check("abort_no_write", rd, 32'h00000000);

        // Zero wait states
        l0_req(1'b1, 3'b010, 32'h4, 32'h5A5A1234, 32'h0);
        l0_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h5A5A1234);
        l0_req(1'b0, 3'b001, 32'h6, 32'h0, 32'h00005A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
